// File: rtl/mem_pkg.sv
// Shared types and configuration checks for the 1R1W memory model and its read pipeline.
package mem_pkg;

   typedef enum logic {
      INIT,
      READY
   } mem_state_e;

   localparam int RD_LAT_MAX = 4;

   // True when the lane split is exact, the read latency is legal and the depth is usable.
   function automatic bit cfg_ok(int width, int lane_w, int rd_lat, int depth);
      return (lane_w > 0) && (width > 0) && ((width % lane_w) == 0) &&
             (rd_lat >= 1) && (rd_lat <= RD_LAT_MAX) && (depth >= 2);
   endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// Valid/data delay line behind the registered array read; STAGES = 0 is a plain pass-through.
module mem_rd_pipe #(
   parameter int WIDTH  = 96,
   parameter int STAGES = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data
);

   if (STAGES == 0) begin : g_pass
      logic unused_clk_rst;

      assign unused_clk_rst = clk ^ rst;
      assign out_valid      = in_valid;
      assign out_data       = in_data;
   end else begin : g_stages
      logic             vld_q [STAGES];
      logic [WIDTH-1:0] dat_q [STAGES];

      // Data only advances behind a valid, so the last word stays visible while idle.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
               vld_q[i] <= 1'b0;
               dat_q[i] <= '0;
            end
         end else begin
            vld_q[0] <= in_valid;
            if (in_valid) begin
               dat_q[0] <= in_data;
            end
            for (int i = 1; i < STAGES; i++) begin
               vld_q[i] <= vld_q[i-1];
               if (vld_q[i-1]) begin
                  dat_q[i] <= dat_q[i-1];
               end
            end
         end
      end

      assign out_valid = vld_q[STAGES-1];
      assign out_data  = dat_q[STAGES-1];
   end

endmodule

// File: rtl/mem_1r1w_init.sv
// 1-read/1-write memory with per-lane write mask, RD_LAT-cycle read pipeline and zero-fill after reset.
// Build option MEM_BYPASS_EN: a same-cycle, same-address read returns the merged new word.
module mem_1r1w_init
   import mem_pkg::*;
#(
   parameter  int WIDTH  = 96,
   parameter  int DEPTH  = 16384,
   parameter  int LANE_W = 8,
   parameter  int RD_LAT = 1,
   localparam int NLANE  = WIDTH / LANE_W,
   localparam int AW     = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rceb,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata,
   output logic             rvalid,
   input  logic             wceb,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [NLANE-1:0] wmask,
   output logic             init_done,
   output logic             oob_err
);

   localparam logic [AW:0]   DEPTH_EXT = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   if (!cfg_ok(WIDTH, LANE_W, RD_LAT, DEPTH)) begin : g_cfg_check
      $error("mem_1r1w_init: WIDTH must be a multiple of LANE_W, RD_LAT in 1..4, DEPTH >= 2");
   end

   logic [WIDTH-1:0] mem [DEPTH];

   mem_state_e       state_q;
   mem_state_e       state_d;
   logic [AW-1:0]    cnt_q;
   logic [AW-1:0]    cnt_d;
   logic             fill_we;
   logic             rd_ok;
   logic             wr_ok;
   logic             rd_in_range;
   logic             wr_in_range;
   logic [WIDTH-1:0] rd_word;
   logic             rd1_valid;
   logic [WIDTH-1:0] rd1_data;

   assign rd_in_range = {1'b0, raddr} < DEPTH_EXT;
   assign wr_in_range = {1'b0, waddr} < DEPTH_EXT;
   assign rd_ok       = (state_q == READY) && !rceb;
   assign wr_ok       = (state_q == READY) && !wceb;
   assign init_done   = (state_q == READY);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= INIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Zero-fill one word per cycle; READY is terminal until the next reset.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      fill_we = 1'b0;
      case (state_q)
         INIT: begin
            fill_we = 1'b1;
            if (cnt_q == LAST_ADDR) begin
               state_d = READY;
            end else begin
               cnt_d = cnt_q + AW'(1);
            end
         end
         READY: begin
            state_d = READY;
         end
         default: begin
            state_d = INIT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (fill_we) begin
         mem[cnt_q] <= '0;
      end else if (wr_ok && wr_in_range) begin
         for (int i = 0; i < NLANE; i++) begin
            if (wmask[i]) begin
               mem[waddr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
            end
         end
      end
   end

`ifdef MEM_BYPASS_EN
   logic bypass_hit;

   assign bypass_hit = wr_ok && wr_in_range && (raddr == waddr);

   // Overlay the lanes being written this cycle onto the word leaving the array.
   always_comb begin
      rd_word = mem[raddr];
      if (bypass_hit) begin
         for (int i = 0; i < NLANE; i++) begin
            if (wmask[i]) begin
               rd_word[i*LANE_W +: LANE_W] = wdata[i*LANE_W +: LANE_W];
            end
         end
      end
   end
`else
   assign rd_word = mem[raddr];
`endif

   // First read stage; out-of-range reads still return a strobe, with zero data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd1_valid <= 1'b0;
         rd1_data  <= '0;
      end else begin
         rd1_valid <= rd_ok;
         if (rd_ok) begin
            rd1_data <= rd_in_range ? rd_word : '0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         oob_err <= 1'b0;
      end else if ((rd_ok && !rd_in_range) || (wr_ok && !wr_in_range)) begin
         oob_err <= 1'b1;
      end
   end

   mem_rd_pipe #(
      .WIDTH  (WIDTH),
      .STAGES (RD_LAT - 1)
   ) u_rd_pipe (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (rd1_valid),
      .in_data   (rd1_data),
      .out_valid (rvalid),
      .out_data  (rdata)
   );

endmodule

// File: tb/tb_mem_1r1w_init.sv
// Scoreboard bench: three memory instances (DEPTH/RD_LAT = 16/1, 12/3, 14/2), reads queued with their expected data and cycle.
module tb_mem_1r1w_init;

   localparam int N = 3;

`ifdef MEM_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   typedef struct {
      int          idx;
      int          addr;
      logic [95:0] data;
      int          cyc;
   } exp_t;

   logic        clk;
   logic        rst       [N];
   logic        rceb      [N];
   logic [3:0]  raddr     [N];
   logic [95:0] rdata     [N];
   logic        rvalid    [N];
   logic        wceb      [N];
   logic [3:0]  waddr     [N];
   logic [95:0] wdata     [N];
   logic [11:0] wmask     [N];
   logic        init_done [N];
   logic        oob_err   [N];

   exp_t sb_q[$];
   int   cyc;
   int   n_checks;
   int   n_fail;
   int   rel;

   mem_1r1w_init #(.WIDTH(96), .DEPTH(16), .LANE_W(8), .RD_LAT(1)) dut_a (
      .clk(clk), .rst(rst[0]), .rceb(rceb[0]), .raddr(raddr[0]), .rdata(rdata[0]),
      .rvalid(rvalid[0]), .wceb(wceb[0]), .waddr(waddr[0]), .wdata(wdata[0]),
      .wmask(wmask[0]), .init_done(init_done[0]), .oob_err(oob_err[0])
   );

   mem_1r1w_init #(.WIDTH(96), .DEPTH(12), .LANE_W(8), .RD_LAT(3)) dut_b (
      .clk(clk), .rst(rst[1]), .rceb(rceb[1]), .raddr(raddr[1]), .rdata(rdata[1]),
      .rvalid(rvalid[1]), .wceb(wceb[1]), .waddr(waddr[1]), .wdata(wdata[1]),
      .wmask(wmask[1]), .init_done(init_done[1]), .oob_err(oob_err[1])
   );

   mem_1r1w_init #(.WIDTH(96), .DEPTH(14), .LANE_W(8), .RD_LAT(2)) dut_c (
      .clk(clk), .rst(rst[2]), .rceb(rceb[2]), .raddr(raddr[2]), .rdata(rdata[2]),
      .rvalid(rvalid[2]), .wceb(wceb[2]), .waddr(waddr[2]), .wdata(wdata[2]),
      .wmask(wmask[2]), .init_done(init_done[2]), .oob_err(oob_err[2])
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int lat_of(int i);
      case (i)
         0:       return 1;
         1:       return 3;
         default: return 2;
      endcase
   endfunction

   function automatic int depth_of(int i);
      case (i)
         0:       return 16;
         1:       return 12;
         default: return 14;
      endcase
   endfunction

   task automatic check_output(string name, logic [95:0] act, logic [95:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic issue_rd_raw(int i, int addr);
      rceb[i]  = 1'b0;
      raddr[i] = 4'(addr);
   endtask

   // Accepted on the coming edge (cyc+1), visible after edge cyc+1+lat-1.
   task automatic issue_rd(int i, int addr, logic [95:0] exp);
      exp_t e;
      issue_rd_raw(i, addr);
      e.idx  = i;
      e.addr = addr;
      e.data = exp;
      e.cyc  = cyc + lat_of(i);
      sb_q.push_back(e);
   endtask

   task automatic issue_wr(int i, int addr, logic [95:0] data, logic [11:0] mask);
      wceb[i]  = 1'b0;
      waddr[i] = 4'(addr);
      wdata[i] = data;
      wmask[i] = mask;
   endtask

   task automatic cycle();
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         rceb[i] = 1'b1;
         wceb[i] = 1'b1;
      end
   endtask

   task automatic monitor_port(int i);
      int k;
      k = -1;
      foreach (sb_q[j]) begin
         if (k < 0 && sb_q[j].idx == i) k = j;
      end
      if (rvalid[i]) begin
         if (k < 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL unexpected rvalid on dut%0d: rdata %h, no read outstanding (cycle %0d)", i, rdata[i], cyc);
         end else begin
            check_output($sformatf("dut%0d rdata addr %0d", i, sb_q[k].addr), rdata[i], sb_q[k].data);
            check_output($sformatf("dut%0d rvalid cycle addr %0d", i, sb_q[k].addr), 96'(cyc), 96'(sb_q[k].cyc));
            sb_q.delete(k);
         end
      end else if (k >= 0 && sb_q[k].cyc <= cyc) begin
         n_checks++;
         n_fail++;
         $display("[TB] FAIL missing rvalid on dut%0d addr %0d: rvalid 0, required 1 at cycle %0d (now %0d)",
                  i, sb_q[k].addr, sb_q[k].cyc, cyc);
         sb_q.delete(k);
      end
   endtask

   always @(negedge clk) begin
      for (int i = 0; i < N; i++) monitor_port(i);
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      n_checks = 0;
      n_fail   = 0;
      for (int i = 0; i < N; i++) begin
         rst[i]   = 1'b1;
         rceb[i]  = 1'b1;
         wceb[i]  = 1'b1;
         raddr[i] = '0;
         waddr[i] = '0;
         wdata[i] = '0;
         wmask[i] = '0;
      end

      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         check_output($sformatf("dut%0d reset rdata", i), rdata[i], '0);
         check_output($sformatf("dut%0d reset rvalid", i), 96'(rvalid[i]), '0);
         check_output($sformatf("dut%0d reset init_done", i), 96'(init_done[i]), '0);
         check_output($sformatf("dut%0d reset oob_err", i), 96'(oob_err[i]), '0);
      end

      // Release all resets together and watch init_done rise after exactly DEPTH edges.
      @(negedge clk);
      for (int i = 0; i < N; i++) rst[i] = 1'b0;
      rel = cyc;
      for (int k = 1; k <= 16; k++) begin
         cycle();
         for (int i = 0; i < N; i++) begin
            check_output($sformatf("dut%0d init_done after %0d edges", i, k),
                         96'(init_done[i]), 96'((cyc - rel) >= depth_of(i)));
         end
         if (k == 9) begin
            issue_wr(1, 7, 96'hBEEF, 12'hFFF);
            issue_rd_raw(1, 14);
         end
      end
      check_output("dut1 oob_err ignored during INIT", 96'(oob_err[1]), '0);

      // dut0: first read right at init_done, lane masking, bypass.
      issue_rd(0, 5, '0);
      cycle();
      issue_wr(0, 3, 96'h0123_4567_89AB_CDEF_0123_45AB, 12'hFFF);
      cycle();
      issue_wr(0, 3, {96{1'b1}}, 12'h001);
      cycle();
      issue_rd(0, 3, 96'h0123_4567_89AB_CDEF_0123_45FF);
      cycle();
      issue_wr(0, 3, {8'hA5, 88'h0}, 12'h800);
      cycle();
      issue_wr(0, 3, '0, 12'h000);
      cycle();
      issue_rd(0, 3, 96'hA523_4567_89AB_CDEF_0123_45FF);
      cycle();
      issue_wr(0, 7, 96'h55, 12'hFFF);
      cycle();
      issue_wr(0, 7, 96'hAA, 12'hFFF);
      issue_rd(0, 7, BYP ? 96'hAA : 96'h55);
      cycle();
      issue_rd(0, 7, 96'hAA);
      cycle();
      issue_wr(0, 8, {12{8'h55}}, 12'hFFF);
      cycle();
      issue_wr(0, 8, {12{8'hAA}}, 12'h003);
      issue_rd(0, 8, BYP ? {{10{8'h55}}, 16'hAAAA} : {12{8'h55}});
      cycle();
      issue_wr(0, 9, 96'h1234, 12'hFFF);
      issue_rd(0, 8, {{10{8'h55}}, 16'hAAAA});
      cycle();
      issue_rd(0, 9, 96'h1234);
      cycle();
      cycle();

      // dut1: back-to-back reads through a 3-deep pipeline, hold, out-of-range access.
      for (int a = 0; a < 4; a++) begin
         issue_wr(1, a, 96'(10 + a), 12'hFFF);
         cycle();
      end
      for (int a = 0; a < 4; a++) begin
         issue_rd(1, a, 96'(10 + a));
         cycle();
      end
      repeat (4) cycle();
      check_output("dut1 rdata held while idle", rdata[1], 96'd13);
      check_output("dut1 rvalid low while idle", 96'(rvalid[1]), '0);
      check_output("dut1 oob_err before oob access", 96'(oob_err[1]), '0);
      issue_rd(1, 14, '0);
      issue_wr(1, 13, 96'hBAD, 12'hFFF);
      cycle();
      check_output("dut1 oob_err set", 96'(oob_err[1]), 96'd1);
      repeat (3) cycle();
      check_output("dut1 oob_err sticky", 96'(oob_err[1]), 96'd1);
      for (int a = 0; a < 12; a++) begin
         issue_rd(1, a, (a < 4) ? 96'(10 + a) : '0);
         cycle();
      end
      repeat (4) cycle();

      // dut2: out-of-range write alone, then reset during a read.
      check_output("dut2 oob_err before oob write", 96'(oob_err[2]), '0);
      issue_wr(2, 15, 96'hBAD, 12'hFFF);
      cycle();
      check_output("dut2 oob_err after oob write", 96'(oob_err[2]), 96'd1);
      issue_wr(2, 2, 96'h77, 12'hFFF);
      cycle();
      issue_rd(2, 2, 96'h77);
      cycle();
      issue_rd_raw(2, 2);
      cycle();
      #2;
      rst[2] = 1'b1;
      #1;
      check_output("dut2 rvalid dropped by reset", 96'(rvalid[2]), '0);
      check_output("dut2 rdata cleared by reset", rdata[2], '0);
      check_output("dut2 init_done cleared by reset", 96'(init_done[2]), '0);
      check_output("dut2 oob_err cleared by reset", 96'(oob_err[2]), '0);
      repeat (2) cycle();
      rst[2] = 1'b0;
      repeat (13) cycle();
      check_output("dut2 init_done before refill end", 96'(init_done[2]), '0);
      cycle();
      check_output("dut2 init_done after refill", 96'(init_done[2]), 96'd1);
      issue_rd(2, 2, '0);
      cycle();
      repeat (5) cycle();

      check_output("scoreboard drained", 96'(sb_q.size()), '0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_1r1w_init.md
# mem_1r1w_init

Parametrised 1-read/1-write synchronous memory model for the testbench and behavioural RTL, generalising the fixed-size single-port memory to any width and depth. It adds an independent read port and write port, per-lane write masking, a configurable read-pipeline latency with a valid strobe, and a hardware zero-fill after reset. It sits next to the decoder datapath as packet/scratch storage. `init_done` gates all use.

## Interface
Parameters:
- `WIDTH`, 96: data word width in bits; must be a multiple of `LANE_W`.
- `DEPTH`, 16384: number of words; any value ≥ 2, not necessarily a power of two.
- `LANE_W`, 8: bits per write-mask lane; `NLANE = WIDTH/LANE_W`.
- `RD_LAT`, 1: read latency in cycles, legal range 1..4.
- `AW`, derived: `$clog2(DEPTH)`.

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `rceb` in 1: read enable, active-low.
- `raddr` in AW: read address.
- `rdata` out WIDTH: read data.
- `rvalid` out 1: one-cycle strobe, `rdata` valid.
- `wceb` in 1: write enable, active-low.
- `waddr` in AW: write address.
- `wdata` in WIDTH: write data.
- `wmask` in NLANE: per-lane write enable, active-high; bit i covers `wdata[i*LANE_W +: LANE_W]`.
- `init_done` out 1: high once zero-fill is complete.
- `oob_err` out 1: sticky, set by any accepted access with address ≥ DEPTH.

## Operation
- FSM states: INIT, READY.
  - Reset enters INIT with the fill counter at 0.
  - INIT writes zero to `mem[cnt]` each cycle, then increments `cnt`. After the `cnt == DEPTH-1` write it moves to READY.
  - READY is terminal until the next reset.
- In INIT, user reads and writes are ignored entirely: no memory change, no `rvalid`, no `oob_err`.
- Write in READY, when `!wceb` and `waddr < DEPTH`: lanes with `wmask[i]=1` update and other lanes keep their value. `wmask == 0` is a legal no-op.
- Read in READY, when `!rceb` and `raddr < DEPTH`: the word is fetched and enters an RD_LAT-deep pipeline.
- Out-of-range accesses (`addr ≥ DEPTH`):
  - a write is dropped;
  - a read still produces `rvalid` with `rdata = 0`;
  - both set `oob_err`, which is cleared only by `rst`.
- Same-address read and write in the same cycle: the behaviour is set by `MEM_BYPASS_EN` (see Configuration).
- Independent addresses on the two ports never interact.

## Timing
- Reset values: `rdata = 0`, `rvalid = 0`, `init_done = 0`, `oob_err = 0`. The pipeline stages are cleared.
- `init_done` rises exactly DEPTH cycles after the first rising edge following `rst` deassertion. The first accepted access is on the edge where `init_done = 1`.
- A read accepted on edge N gives `rvalid = 1` and `rdata` after edge N+RD_LAT−1, so the data is visible in cycle N+RD_LAT−1. RD_LAT=1 matches a plain registered SRAM read.
- Back-to-back reads give back-to-back `rvalid` at full throughput.
- `rdata` holds its last value while `rvalid = 0`.
- A write accepted on edge N is visible to a read accepted on edge N+1 or later.
- Asserting `rst` mid-operation:
  - flushes the pipeline and drops `rvalid` immediately (asynchronously);
  - restarts INIT, so memory is re-zeroed.

## Configuration
- `MEM_BYPASS_EN` defined: on a same-cycle, same-address read and write, the read returns the merged new word (masked lanes from `wdata`, other lanes from the old contents).
- `MEM_BYPASS_EN` undefined: the read returns the old word (read-before-write).
- Writes, latency and all other behaviour are identical in both builds.

## Structure
- Shared package `mem_pkg`:
  - `mem_state_e` enum {INIT, READY};
  - `RD_LAT_MAX = 4`;
  - an elaboration-time check function for the WIDTH/LANE_W divisibility and the RD_LAT range.
- Sub-module `mem_rd_pipe`: a parametrised valid/data delay line of depth RD_LAT−1 with async clear, which is a pass-through when RD_LAT=1.
- Top level: memory array, write-merge logic, bypass compare, INIT FSM and fill counter.

## Test plan
- Reset, DEPTH=16, RD_LAT=1 → `init_done` rises on edge 16. A read of addr 5 at the next edge gives `rvalid` with `rdata = 0` one cycle later.
- Write `0x0123…AB` (all lanes) to addr 3, then write `wdata = 0xFF…FF` with `wmask = 0x001` to addr 3, then read → only lane 0 is `0xFF`; the other lanes are unchanged.
- RD_LAT=3, 4 consecutive reads of addrs 0–3 holding values 10–13 → `rvalid` high for 4 consecutive cycles starting 2 cycles after the first accept, with data 10, 11, 12, 13 in order.
- Same-cycle write of 0xAA and read of addr 7 (old value 0x55) → 0xAA with `MEM_BYPASS_EN`, 0x55 without. A following read returns 0xAA in both builds.
- DEPTH=12, read addr 14 and write addr 13 → the read gives `rvalid` with `rdata = 0`; `oob_err` is set and sticks; addrs 0–11 are unchanged.
- Assert `rst` mid-read with RD_LAT=2 after writing 0x77 to addr 2 → `rvalid` drops at once, `init_done = 0`, and a read of addr 2 after re-init returns 0.
